// File: rtl/uart_pkg.sv
// uart_pkg: shared UART transmitter state type, frame defaults and clocking constants
package uart_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_tx_state_t;
  localparam int UART_DATA_BITS = 8;
  localparam int UART_STOP_BITS = 1;
  localparam int SYS_CLOCK = 100_000_000;
  localparam int BAUDRATE = 115_200;
endpackage

// File: rtl/uart_tx.sv
// uart_tx: tick-aligned asynchronous serial transmitter with optional parity and 1/2 stop bits
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS = UART_DATA_BITS,
  parameter int PARITY_EN = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS = UART_STOP_BITS
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 bps_tick,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 tx_busy,
  output logic                 tx_done
);
  uart_tx_state_t state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic stop_cnt_q, stop_cnt_d;
  logic par_q, par_d;
  logic txd_q, txd_d;
  logic done_q, done_d;
  // next-state and next-output logic; every line change is gated by a sampled tick
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bit_cnt_d = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d = par_q;
    txd_d = txd_q;
    done_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        txd_d = 1'b1;
        if (tx_valid) begin
          shift_d = tx_data;
          par_d = (^tx_data) ^ (PARITY_ODD != 0);
          state_d = ST_ARM;
        end
      end
      ST_ARM: if (bps_tick) begin
        txd_d = 1'b0;
        state_d = ST_START;
      end
      ST_START: if (bps_tick) begin
        txd_d = shift_q[0];
        bit_cnt_d = 3'd0;
        state_d = ST_DATA;
      end
      ST_DATA: if (bps_tick) begin
        if (bit_cnt_q != 3'(DATA_BITS - 1)) begin
          shift_d = shift_q >> 1;
          txd_d = shift_q[1];
          bit_cnt_d = bit_cnt_q + 3'd1;
        end else if (PARITY_EN != 0) begin
          txd_d = par_q;
          state_d = ST_PARITY;
        end else begin
          txd_d = 1'b1;
          stop_cnt_d = 1'b0;
          state_d = ST_STOP;
        end
      end
      ST_PARITY: if (bps_tick) begin
        txd_d = 1'b1;
        stop_cnt_d = 1'b0;
        state_d = ST_STOP;
      end
      ST_STOP: if (bps_tick) begin
        if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
          state_d = ST_IDLE;
          done_d = 1'b1;
        end else begin
          stop_cnt_d = stop_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d = 1'b1;
      end
    endcase
  end
  // state and output registers; reset abandons any frame and returns the line high
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      shift_q <= '0;
      bit_cnt_q <= 3'd0;
      stop_cnt_q <= 1'b0;
      par_q <= 1'b0;
      txd_q <= 1'b1;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_q <= par_d;
      txd_q <= txd_d;
      done_q <= done_d;
    end
  end
  assign tx_ready = (state_q == ST_IDLE);
  assign tx_busy = !tx_ready;
  assign txd = txd_q;
  assign tx_done = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: table-driven and randomized frame checks over five transmitter configurations
module tb_uart_tx;
  localparam int P = 16;
  logic clk = 1'b0;
  logic rst;
  logic bps_tick;
  int tcnt;
  logic [7:0] tx_data_s [5];
  logic tx_valid_s [5];
  logic tx_ready_s [5];
  logic txd_s [5];
  logic tx_busy_s [5];
  logic tx_done_s [5];
  int checks = 0;
  int failures = 0;
  int w_g;
  logic smp[$];
  typedef struct {
    int cfg;
    logic [7:0] data;
    logic par;
    int ticks;
  } vec_t;
  vec_t vecs[5];

  always #5 clk = ~clk;

  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
    .sys_clk(clk), .rst(rst), .bps_tick(bps_tick), .tx_data(tx_data_s[0]), .tx_valid(tx_valid_s[0]),
    .tx_ready(tx_ready_s[0]), .txd(txd_s[0]), .tx_busy(tx_busy_s[0]), .tx_done(tx_done_s[0]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_8e1 (
    .sys_clk(clk), .rst(rst), .bps_tick(bps_tick), .tx_data(tx_data_s[1]), .tx_valid(tx_valid_s[1]),
    .tx_ready(tx_ready_s[1]), .txd(txd_s[1]), .tx_busy(tx_busy_s[1]), .tx_done(tx_done_s[1]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_8o1 (
    .sys_clk(clk), .rst(rst), .bps_tick(bps_tick), .tx_data(tx_data_s[2]), .tx_valid(tx_valid_s[2]),
    .tx_ready(tx_ready_s[2]), .txd(txd_s[2]), .tx_busy(tx_busy_s[2]), .tx_done(tx_done_s[2]));
  uart_tx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_8n2 (
    .sys_clk(clk), .rst(rst), .bps_tick(bps_tick), .tx_data(tx_data_s[3]), .tx_valid(tx_valid_s[3]),
    .tx_ready(tx_ready_s[3]), .txd(txd_s[3]), .tx_busy(tx_busy_s[3]), .tx_done(tx_done_s[3]));
  uart_tx #(.DATA_BITS(5), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)) u_5o2 (
    .sys_clk(clk), .rst(rst), .bps_tick(bps_tick), .tx_data(tx_data_s[4][4:0]), .tx_valid(tx_valid_s[4]),
    .tx_ready(tx_ready_s[4]), .txd(txd_s[4]), .tx_busy(tx_busy_s[4]), .tx_done(tx_done_s[4]));

  function automatic int db(input int c);
    return (c == 4) ? 5 : 8;
  endfunction
  function automatic int pe(input int c);
    return (c == 1 || c == 2 || c == 4) ? 1 : 0;
  endfunction
  function automatic int po(input int c);
    return (c == 2 || c == 4) ? 1 : 0;
  endfunction
  function automatic int sb(input int c);
    return (c == 3 || c == 4) ? 2 : 1;
  endfunction

  function automatic logic exp_bit(input int c, input logic [7:0] d, input int k);
    logic [7:0] m;
    m = d & (8'hFF >> (8 - db(c)));
    if (k == 0) return 1'b0;
    if (k <= db(c)) return d[k-1];
    if (pe(c) != 0 && k == db(c) + 1) return logic'(($countones(m) % 2) == 1) ^ logic'(po(c) != 0);
    return 1'b1;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic capture(input int c);
    int n;
    int bb;
    w_g = 0;
    while (txd_s[c] === 1'b1 && w_g < 2 * P + 4) begin
      @(negedge clk);
      w_g++;
    end
    chk($sformatf("cfg%0d_start_seen", c), 32'(txd_s[c]), 0);
    smp.delete();
    n = 0;
    bb = 0;
    while (tx_done_s[c] !== 1'b1 && n < 16 * P) begin
      smp.push_back(txd_s[c]);
      if (tx_busy_s[c] !== 1'b1 || tx_ready_s[c] !== 1'b0) bb++;
      @(negedge clk);
      n++;
    end
    chk($sformatf("cfg%0d_busy_in_frame", c), bb, 0);
    chk($sformatf("cfg%0d_done_seen", c), 32'(tx_done_s[c]), 1);
  endtask

  task automatic check_model(input int c, input logic [7:0] d);
    int nb;
    int bad;
    int idx;
    nb = 1 + db(c) + pe(c) + sb(c);
    chk($sformatf("cfg%0d_d%02h_frame_cycles", c, d), smp.size(), nb * P);
    for (int k = 0; k < nb; k++) begin
      bad = 0;
      for (int j = 0; j < P; j++) begin
        idx = k * P + j;
        if (idx >= smp.size() || smp[idx] !== exp_bit(c, d, k)) bad++;
      end
      chk($sformatf("cfg%0d_d%02h_bit%0d_bad_cycles", c, d, k), bad, 0);
    end
    chk($sformatf("cfg%0d_ready_at_done", c), 32'(tx_ready_s[c]), 1);
    chk($sformatf("cfg%0d_txd_at_done", c), 32'(txd_s[c]), 1);
  endtask

  task automatic send(input int c, input logic [7:0] d);
    chk($sformatf("cfg%0d_ready_before", c), 32'(tx_ready_s[c]), 1);
    tx_data_s[c] = d;
    tx_valid_s[c] = 1'b1;
    @(negedge clk);
    tx_valid_s[c] = 1'b0;
    chk($sformatf("cfg%0d_busy_after_hs", c), 32'(tx_busy_s[c]), 1);
    capture(c);
    chk($sformatf("cfg%0d_start_latency_in_range", c), 32'(w_g >= 1 && w_g <= P), 1);
    check_model(c, d);
    @(negedge clk);
    chk($sformatf("cfg%0d_done_single_cycle", c), 32'(tx_done_s[c]), 0);
  endtask

  initial begin
    tcnt = 0;
    bps_tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tcnt = (tcnt == P - 1) ? 0 : tcnt + 1;
      bps_tick = (tcnt == P - 1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    int idx;
    logic [7:0] d;
    vecs[0] = '{0, 8'h55, 1'b0, 10};
    vecs[1] = '{1, 8'h07, 1'b1, 11};
    vecs[2] = '{2, 8'h07, 1'b0, 11};
    vecs[3] = '{4, 8'h13, 1'b0, 9};
    vecs[4] = '{3, 8'hA3, 1'b0, 11};
    rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tx_data_s[c] = 8'h00;
      tx_valid_s[c] = 1'b0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("cfg%0d_rst_txd", c), 32'(txd_s[c]), 1);
      chk($sformatf("cfg%0d_rst_ready", c), 32'(tx_ready_s[c]), 1);
      chk($sformatf("cfg%0d_rst_busy", c), 32'(tx_busy_s[c]), 0);
      chk($sformatf("cfg%0d_rst_done", c), 32'(tx_done_s[c]), 0);
    end
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].cfg, vecs[i].data);
      chk($sformatf("vec%0d_ticks", i), smp.size() / P, vecs[i].ticks);
      if (pe(vecs[i].cfg) != 0) begin
        idx = (1 + db(vecs[i].cfg)) * P + P / 2;
        chk($sformatf("vec%0d_parity", i), 32'((idx < smp.size()) ? smp[idx] : 1'bx), 32'(vecs[i].par));
      end
    end
    for (int c = 0; c < 5; c++) begin
      for (int r = 0; r < 4; r++) begin
        repeat ($urandom_range(0, P)) @(negedge clk);
        send(c, 8'($urandom));
      end
    end
    tx_data_s[3] = 8'hA3;
    tx_valid_s[3] = 1'b1;
    @(negedge clk);
    tx_data_s[3] = 8'h3C;
    capture(3);
    check_model(3, 8'hA3);
    @(negedge clk);
    tx_valid_s[3] = 1'b0;
    chk("b2b_second_handshake", 32'(tx_busy_s[3]), 1);
    capture(3);
    chk("b2b_gap_within_tick", 32'(w_g <= P), 1);
    check_model(3, 8'h3C);
    @(negedge clk);
    n = 0;
    while (bps_tick !== 1'b1 && n < P + 2) begin
      @(negedge clk);
      n++;
    end
    chk("tick_found", 32'(bps_tick), 1);
    d = 8'($urandom);
    tx_data_s[0] = d;
    tx_valid_s[0] = 1'b1;
    @(negedge clk);
    tx_valid_s[0] = 1'b0;
    capture(0);
    chk("tick_hs_start_latency", w_g, P);
    check_model(0, d);
    @(negedge clk);
    tx_data_s[0] = 8'h00;
    tx_valid_s[0] = 1'b1;
    @(negedge clk);
    tx_valid_s[0] = 1'b0;
    fork
      capture(0);
      begin
        repeat (4 * P) @(negedge clk);
        tx_data_s[0] = 8'hFF;
      end
    join
    check_model(0, 8'h00);
    @(negedge clk);
    d = 8'($urandom) & 8'hEF;
    tx_data_s[0] = d;
    tx_valid_s[0] = 1'b1;
    @(negedge clk);
    tx_valid_s[0] = 1'b0;
    n = 0;
    while (txd_s[0] === 1'b1 && n < 2 * P + 4) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid_start_seen", 32'(txd_s[0]), 0);
    repeat (5 * P + P / 2) @(negedge clk);
    chk("rstmid_bit4_low", 32'(txd_s[0]), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstmid_txd", 32'(txd_s[0]), 1);
    chk("rstmid_ready", 32'(tx_ready_s[0]), 1);
    chk("rstmid_busy", 32'(tx_busy_s[0]), 0);
    chk("rstmid_done", 32'(tx_done_s[0]), 0);
    bad = 0;
    repeat (3 * P) begin
      @(negedge clk);
      if (tx_done_s[0] !== 1'b0 || txd_s[0] !== 1'b1) bad++;
    end
    chk("rstmid_quiet_after", bad, 0);
    send(0, 8'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
